// File: rtl/pc_redirect_unit_pkg.sv
// Shared fetch-redirect definitions: branch opcode, FSM encoding and the
// sequential PC increment.
package pc_redirect_unit_pkg;

    // Major opcode of conditional branches (B-type).
    localparam logic [6:0] OPC_B_TYPE = 7'b1100011;

    // Byte distance between consecutive sequential fetches.
    localparam int unsigned PC_INCR = 4;

    // Fetch-redirect FSM encoding.
    typedef enum logic [1:0] {
        ST_BOOT    = 2'd0,
        ST_RUN     = 2'd1,
        ST_RECOVER = 2'd2
    } redirect_state_t;

endpackage

// File: rtl/branch_shadow_reg.sv
// One stage of the branch shadow pipeline: remembers what was predicted for
// the branch currently in the matching main-pipeline stage.
module branch_shadow_reg #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_en,
    input  logic                  i_clr,
    input  logic                  i_valid,
    input  logic                  i_pred_taken,
    input  logic [DATA_WIDTH-1:0] i_pred_target,
    input  logic [DATA_WIDTH-1:0] i_pc,
    output logic                  o_valid,
    output logic                  o_pred_taken,
    output logic [DATA_WIDTH-1:0] o_pred_target,
    output logic [DATA_WIDTH-1:0] o_pc
);

    logic                  r_valid;
    logic                  r_pred_taken;
    logic [DATA_WIDTH-1:0] r_pred_target;
    logic [DATA_WIDTH-1:0] r_pc;

    // Clear wins over load so a squash can never be overwritten by a shift.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid       <= 1'b0;
            r_pred_taken  <= 1'b0;
            r_pred_target <= '0;
            r_pc          <= '0;
        end else if (i_clr) begin
            r_valid       <= 1'b0;
            r_pred_taken  <= 1'b0;
            r_pred_target <= '0;
            r_pc          <= '0;
        end else if (i_en) begin
            r_valid       <= i_valid;
            r_pred_taken  <= i_pred_taken;
            r_pred_target <= i_pred_target;
            r_pc          <= i_pc;
        end
    end

    assign o_valid       = r_valid;
    assign o_pred_taken  = r_pred_taken;
    assign o_pred_target = r_pred_target;
    assign o_pc          = r_pc;

endmodule

// File: rtl/pc_redirect_unit.sv
// Fetch PC generation with predicted-taken redirect in ID and mispredict
// recovery when the branch resolves in EX/MEM. No handshakes: every input is
// sampled each cycle; i_stall freezes fetch unless a mispredict overrides it.
module pc_redirect_unit
    import pc_redirect_unit_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h0,
    parameter int                    CNT_WIDTH  = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_stall,
    input  logic [DATA_WIDTH-1:0] id_pc,
    input  logic                  id_is_branch,
    input  logic                  prediction,
    input  logic [DATA_WIDTH-1:0] branch_target,
    input  logic                  ex_mem_is_branch,
    input  logic                  ex_mem_branch_taken,
    input  logic [DATA_WIDTH-1:0] ex_mem_branch_target,
    output logic [DATA_WIDTH-1:0] o_pc,
    output logic                  o_fetch_valid,
    output logic                  o_flush_if_id,
    output logic                  o_flush_id_ex,
    output logic                  o_mispredict,
    output logic [CNT_WIDTH-1:0]  o_branch_cnt,
    output logic [CNT_WIDTH-1:0]  o_mispredict_cnt
);

    redirect_state_t       r_state;
    redirect_state_t       w_state_nxt;
    logic [DATA_WIDTH-1:0] r_pc;
    logic [DATA_WIDTH-1:0] w_pc_nxt;
    logic [CNT_WIDTH-1:0]  r_branch_cnt;
    logic [CNT_WIDTH-1:0]  r_mispredict_cnt;

    logic                  w_ex_valid;
    logic                  w_ex_pred_taken;
    logic [DATA_WIDTH-1:0] w_ex_pred_target;
    logic [DATA_WIDTH-1:0] w_ex_pc;
    logic                  w_mem_valid;
    logic                  w_mem_pred_taken;
    logic [DATA_WIDTH-1:0] w_mem_pred_target;
    logic [DATA_WIDTH-1:0] w_mem_pc;

    logic                  w_in_boot;
    logic                  w_slot_en;
    logic                  w_slot_clr;
    logic                  w_resolve;
    logic                  w_dir_wrong;
    logic                  w_tgt_wrong;
    logic                  w_mispredict;
    logic                  w_id_redirect;
    logic                  w_fetch_valid;
    logic [DATA_WIDTH-1:0] w_pc_seq;
    logic [DATA_WIDTH-1:0] w_corrected_pc;

    assign w_in_boot = (r_state == ST_BOOT);

    // A resolving branch only counts if its shadow entry survived squashes.
    assign w_resolve   = ex_mem_is_branch & w_mem_valid;
    assign w_dir_wrong = (ex_mem_branch_taken != w_mem_pred_taken);
    assign w_tgt_wrong = ex_mem_branch_taken & w_mem_pred_taken &
                         (ex_mem_branch_target != w_mem_pred_target);
    // RECOVER cannot see a live slot, gating on RUN just makes that explicit.
    assign w_mispredict = (r_state == ST_RUN) & w_resolve & (w_dir_wrong | w_tgt_wrong);

    assign w_pc_seq       = r_pc + DATA_WIDTH'(PC_INCR);
    assign w_corrected_pc = ex_mem_branch_taken ? ex_mem_branch_target
                                                : (w_mem_pc + DATA_WIDTH'(PC_INCR));

    // ID redirect loses to both a stall and an older mispredict.
    assign w_id_redirect = ~w_in_boot & ~i_stall & id_is_branch & prediction & ~w_mispredict;

    // Shadow slots shift with the main pipeline; squash on mispredict and while booting.
    assign w_slot_en  = ~i_stall;
    assign w_slot_clr = w_mispredict | w_in_boot;

    branch_shadow_reg #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_slot_ex (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_en          (w_slot_en),
        .i_clr         (w_slot_clr),
        .i_valid       (id_is_branch),
        .i_pred_taken  (prediction),
        .i_pred_target (branch_target),
        .i_pc          (id_pc),
        .o_valid       (w_ex_valid),
        .o_pred_taken  (w_ex_pred_taken),
        .o_pred_target (w_ex_pred_target),
        .o_pc          (w_ex_pc)
    );

    branch_shadow_reg #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_slot_mem (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_en          (w_slot_en),
        .i_clr         (w_slot_clr),
        .i_valid       (w_ex_valid),
        .i_pred_taken  (w_ex_pred_taken),
        .i_pred_target (w_ex_pred_target),
        .i_pc          (w_ex_pc),
        .o_valid       (w_mem_valid),
        .o_pred_taken  (w_mem_pred_taken),
        .o_pred_target (w_mem_pred_target),
        .o_pc          (w_mem_pc)
    );

    // FSM state register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_BOOT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state and fetch-valid decode.
    always_comb begin
        w_state_nxt   = r_state;
        w_fetch_valid = 1'b0;
        case (r_state)
            ST_BOOT: begin
                w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                w_fetch_valid = 1'b1;
                if (w_mispredict) begin
                    w_state_nxt = ST_RECOVER;
                end
            end
            ST_RECOVER: begin
                w_state_nxt = ST_RUN;
            end
            default: begin
                w_state_nxt = ST_BOOT;
            end
        endcase
    end

    // Next fetch address by priority: boot hold, mispredict, stall, ID redirect, sequential.
    always_comb begin
        w_pc_nxt = r_pc;
        if (w_in_boot) begin
            w_pc_nxt = r_pc;
        end else if (w_mispredict) begin
            w_pc_nxt = w_corrected_pc;
        end else if (i_stall) begin
            w_pc_nxt = r_pc;
        end else if (w_id_redirect) begin
            w_pc_nxt = branch_target;
        end else begin
            w_pc_nxt = w_pc_seq;
        end
    end

    // Fetch PC register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pc <= RESET_PC;
        end else begin
            r_pc <= w_pc_nxt;
        end
    end

    // Saturating statistics counters.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_branch_cnt     <= '0;
            r_mispredict_cnt <= '0;
        end else begin
            if (w_resolve && (r_branch_cnt != '1)) begin
                r_branch_cnt <= r_branch_cnt + CNT_WIDTH'(1);
            end
            if (w_mispredict && (r_mispredict_cnt != '1)) begin
                r_mispredict_cnt <= r_mispredict_cnt + CNT_WIDTH'(1);
            end
        end
    end

    assign o_pc             = r_pc;
    assign o_fetch_valid    = w_fetch_valid;
    assign o_mispredict     = w_mispredict;
    assign o_flush_if_id    = w_in_boot | w_mispredict | w_id_redirect;
    assign o_flush_id_ex    = w_in_boot | w_mispredict;
    assign o_branch_cnt     = r_branch_cnt;
    assign o_mispredict_cnt = r_mispredict_cnt;

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Bench for pc_redirect_unit: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
// A second instance with 4-bit counters exercises counter saturation.
module tb_pc_redirect_unit;

    localparam int DW = 32;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    // ---------------- stimulus ----------------
    logic          stall;
    logic [DW-1:0] id_pc;
    logic          id_is_branch;
    logic          prediction;
    logic [DW-1:0] branch_target;
    logic          exb;
    logic          ext;
    logic [DW-1:0] ex_tgt;

    // ---------------- DUT outputs ----------------
    logic [DW-1:0] pc;
    logic          fv, fif, fie, mp;
    logic [15:0]   bcnt, mcnt;
    logic [DW-1:0] s_pc;
    logic          s_fv, s_fif, s_fie, s_mp;
    logic [3:0]    s_bcnt, s_mcnt;

    pc_redirect_unit u_dut (
        .i_clk                (clk),
        .i_rst_n              (rst_n),
        .i_stall              (stall),
        .id_pc                (id_pc),
        .id_is_branch         (id_is_branch),
        .prediction           (prediction),
        .branch_target        (branch_target),
        .ex_mem_is_branch     (exb),
        .ex_mem_branch_taken  (ext),
        .ex_mem_branch_target (ex_tgt),
        .o_pc                 (pc),
        .o_fetch_valid        (fv),
        .o_flush_if_id        (fif),
        .o_flush_id_ex        (fie),
        .o_mispredict         (mp),
        .o_branch_cnt         (bcnt),
        .o_mispredict_cnt     (mcnt)
    );

    pc_redirect_unit #(.CNT_WIDTH(4)) u_dut_sat (
        .i_clk                (clk),
        .i_rst_n              (rst_n),
        .i_stall              (stall),
        .id_pc                (id_pc),
        .id_is_branch         (id_is_branch),
        .prediction           (prediction),
        .branch_target        (branch_target),
        .ex_mem_is_branch     (exb),
        .ex_mem_branch_taken  (ext),
        .ex_mem_branch_target (ex_tgt),
        .o_pc                 (s_pc),
        .o_fetch_valid        (s_fv),
        .o_flush_if_id        (s_fif),
        .o_flush_id_ex        (s_fie),
        .o_mispredict         (s_mp),
        .o_branch_cnt         (s_bcnt),
        .o_mispredict_cnt     (s_mcnt)
    );

    // ---------------- scoreboard counters ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Branches in flight between ID and resolution, oldest at index 1.
    typedef struct packed {
        logic          valid;
        logic          pred_taken;
        logic [DW-1:0] pred_target;
        logic [DW-1:0] pc;
    } slot_t;

    slot_t         m_slot [2];
    logic [DW-1:0] m_pc;
    bit            m_booted;     // first cycle after reset has passed
    bit            m_last_mp;    // previous cycle was a mispredict
    int            m_branches;   // unbounded counts, clipped when compared
    int            m_mispredicts;
    logic          exp_mp;

    assign exp_mp = m_booted && exb && m_slot[1].valid &&
                    ((ext != m_slot[1].pred_taken) ||
                     (ext && (ex_tgt != m_slot[1].pred_target)));

    function automatic logic [31:0] clip(input int v, input int max_v);
        if (v > max_v) return 32'(max_v);
        return 32'(v);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pc          <= 32'h0;
            m_booted      <= 1'b0;
            m_last_mp     <= 1'b0;
            m_branches    <= 0;
            m_mispredicts <= 0;
            m_slot[0]     <= '0;
            m_slot[1]     <= '0;
        end else if (!m_booted) begin
            m_booted  <= 1'b1;
            m_slot[0] <= '0;
            m_slot[1] <= '0;
        end else begin
            m_last_mp <= exp_mp;
            if (exb && m_slot[1].valid) m_branches <= m_branches + 1;
            if (exp_mp) m_mispredicts <= m_mispredicts + 1;
            if (exp_mp) begin
                m_pc      <= ext ? ex_tgt : (m_slot[1].pc + 32'd4);
                m_slot[0] <= '0;
                m_slot[1] <= '0;
            end else if (!stall) begin
                m_pc      <= (id_is_branch && prediction) ? branch_target : (m_pc + 32'd4);
                m_slot[1] <= m_slot[0];
                m_slot[0] <= {id_is_branch, prediction, branch_target, id_pc};
            end
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        check("mispredict",     32'(mp),  32'(exp_mp));
        check("flush_if_id",    32'(fif), 32'(!m_booted || exp_mp || (!stall && id_is_branch && prediction)));
        check("flush_id_ex",    32'(fie), 32'(!m_booted || exp_mp));
        check("fetch_valid",    32'(fv),  32'(m_booted && !m_last_mp));
        check("pc",             pc,       m_pc);
        check("branch_cnt",     32'(bcnt), clip(m_branches, 65535));
        check("mispredict_cnt", 32'(mcnt), clip(m_mispredicts, 65535));
        check("sat_pc",         s_pc,      m_pc);
        check("sat_branch_cnt", 32'(s_bcnt), clip(m_branches, 15));
        check("sat_mispredict_cnt", 32'(s_mcnt), clip(m_mispredicts, 15));
    end

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        stall         = 1'b0;
        id_is_branch  = 1'b0;
        prediction    = 1'b0;
        id_pc         = '0;
        branch_target = '0;
        exb           = 1'b0;
        ext           = 1'b0;
        ex_tgt        = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic id_branch(input logic pred, input logic [DW-1:0] bpc, input logic [DW-1:0] tgt);
        id_is_branch  = 1'b1;
        prediction    = pred;
        id_pc         = bpc;
        branch_target = tgt;
    endtask

    task automatic resolve(input logic taken, input logic [DW-1:0] tgt);
        exb    = 1'b1;
        ext    = taken;
        ex_tgt = tgt;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        check("rst_pc", pc, 32'h0);
        check("rst_fetch_valid", 32'(fv), 32'h0);
        check("rst_mispredict", 32'(mp), 32'h0);
        check("rst_branch_cnt", 32'(bcnt), 32'h0);
        check("rst_mispredict_cnt", 32'(mcnt), 32'h0);
        check("rst_flush_if_id", 32'(fif), 32'h1);

        // Reset release: one BOOT cycle, then sequential fetch.
        rst_n = 1'b1;
        @(negedge clk);
        check("boot_fetch_valid", 32'(fv), 32'h0);
        check("boot_pc", pc, 32'h0);
        next_cycle();
        check("run_fetch_valid", 32'(fv), 32'h1);
        check("run_pc", pc, 32'h0);
        next_cycle();
        check("seq_pc", pc, 32'h4);

        // Predicted-taken branch at 0x10 -> 0x40.
        id_branch(1'b1, 32'h10, 32'h40);
        @(negedge clk);
        check("pt_flush_if_id", 32'(fif), 32'h1);
        check("pt_flush_id_ex", 32'(fie), 32'h0);
        next_cycle();
        check("pt_pc", pc, 32'h40);
        idle_inputs();

        // Predicted not-taken at 0x20, resolves taken to 0x80.
        id_branch(1'b0, 32'h20, 32'h24);
        next_cycle();
        idle_inputs();
        next_cycle();
        resolve(1'b1, 32'h80);
        @(negedge clk);
        check("nt_mispredict", 32'(mp), 32'h1);
        check("nt_flush_id_ex", 32'(fie), 32'h1);
        next_cycle();
        check("nt_pc", pc, 32'h80);
        check("nt_recover_fv", 32'(fv), 32'h0);
        check("nt_mispredict_cnt", 32'(mcnt), 32'h1);
        // ex_mem_is_branch stays high but the shadow slot is gone.
        resolve(1'b0, 32'h0);
        @(negedge clk);
        check("stale_no_mispredict", 32'(mp), 32'h0);
        next_cycle();
        check("stale_no_count", 32'(bcnt), 32'h1);
        check("recover_done_fv", 32'(fv), 32'h1);
        check("recover_done_pc", pc, 32'h84);
        idle_inputs();

        // Predicted taken 0x40 at pc 0x20, resolves not-taken.
        id_branch(1'b1, 32'h20, 32'h40);
        next_cycle();
        check("ptnt_pred_pc", pc, 32'h40);
        idle_inputs();
        next_cycle();
        resolve(1'b0, 32'h0);
        @(negedge clk);
        check("ptnt_flush_if_id", 32'(fif), 32'h1);
        check("ptnt_flush_id_ex", 32'(fie), 32'h1);
        next_cycle();
        check("ptnt_pc", pc, 32'h24);
        check("ptnt_mispredict_cnt", 32'(mcnt), 32'h2);
        idle_inputs();
        next_cycle();

        // Direction right, target wrong.
        id_branch(1'b1, 32'h44, 32'h60);
        next_cycle();
        idle_inputs();
        next_cycle();
        resolve(1'b1, 32'h70);
        @(negedge clk);
        check("tgt_mispredict", 32'(mp), 32'h1);
        next_cycle();
        check("tgt_pc", pc, 32'h70);
        idle_inputs();
        next_cycle();

        // Correct prediction: counted, no mispredict.
        id_branch(1'b1, 32'h74, 32'h90);
        next_cycle();
        idle_inputs();
        next_cycle();
        resolve(1'b1, 32'h90);
        @(negedge clk);
        check("ok_no_mispredict", 32'(mp), 32'h0);
        next_cycle();
        check("ok_pc", pc, 32'h98);
        check("ok_branch_cnt", 32'(bcnt), 32'h4);
        check("ok_mispredict_cnt", 32'(mcnt), 32'h3);
        idle_inputs();

        // Plain stall holds the PC.
        stall = 1'b1;
        next_cycle();
        check("stall_hold_pc", pc, 32'h98);
        stall = 1'b0;
        next_cycle();
        check("unstall_pc", pc, 32'h9c);

        // Mispredict during a stall with a predicted-taken branch in ID.
        id_branch(1'b0, 32'h30, 32'h34);
        next_cycle();
        idle_inputs();
        next_cycle();
        stall = 1'b1;
        id_branch(1'b1, 32'h50, 32'h100);
        resolve(1'b1, 32'h200);
        @(negedge clk);
        check("stall_mp_mispredict", 32'(mp), 32'h1);
        next_cycle();
        check("stall_mp_pc", pc, 32'h200);
        check("stall_mp_fv", 32'(fv), 32'h0);
        check("stall_mp_branch_cnt", 32'(bcnt), 32'h5);
        idle_inputs();
        next_cycle();
        check("stall_mp_after_pc", pc, 32'h204);

        // Corrected PC at top of address space, then sequential wrap.
        id_branch(1'b0, 32'h204, 32'h208);
        next_cycle();
        idle_inputs();
        next_cycle();
        resolve(1'b1, 32'hFFFF_FFFC);
        next_cycle();
        check("wrap_top_pc", pc, 32'hFFFF_FFFC);
        idle_inputs();
        next_cycle();
        check("wrap_pc", pc, 32'h0);

        // Reset asserted while recovering abandons the redirect.
        id_branch(1'b0, 32'h0, 32'h4);
        next_cycle();
        idle_inputs();
        next_cycle();
        resolve(1'b1, 32'h300);
        next_cycle();
        check("midrec_pc_before", pc, 32'h300);
        idle_inputs();
        rst_n = 1'b0;
        #1;
        check("midrec_rst_pc", pc, 32'h0);
        check("midrec_rst_fv", 32'(fv), 32'h0);
        check("midrec_rst_mcnt", 32'(mcnt), 32'h0);
        next_cycle();
        rst_n = 1'b1;
        @(negedge clk);
        check("midrec_boot_fv", 32'(fv), 32'h0);
        next_cycle();
        check("midrec_run_fv", 32'(fv), 32'h1);
        next_cycle();
        check("midrec_seq_pc", pc, 32'h4);

        // Randomized traffic, checked by the compare process each cycle.
        for (int i = 0; i < 600; i++) begin
            stall         = ($urandom_range(0, 4) == 0);
            id_is_branch  = ($urandom_range(0, 1) == 1);
            prediction    = ($urandom_range(0, 1) == 1);
            id_pc         = 32'($urandom_range(0, 255)) << 2;
            branch_target = 32'h100 + (32'($urandom_range(0, 3)) << 2);
            exb           = ($urandom_range(0, 2) != 0);
            ext           = ($urandom_range(0, 1) == 1);
            ex_tgt        = 32'h100 + (32'($urandom_range(0, 3)) << 2);
            next_cycle();
        end
        idle_inputs();
        repeat (3) next_cycle();

        // Counters past saturation: one more correctly predicted branch.
        check("sat_setup", 32'(m_branches >= 15), 32'h1);
        id_branch(1'b0, 32'h400, 32'h404);
        next_cycle();
        idle_inputs();
        next_cycle();
        resolve(1'b0, 32'h0);
        next_cycle();
        idle_inputs();
        check("sat_branch_cnt_hold", 32'(s_bcnt), 32'hF);
        next_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_redirect_unit.md
PC_REDIRECT_UNIT -- requirements
Module: pc_redirect_unit

Interface
REQ-001 SHALL have parameters: DATA_WIDTH, default 32, PC/target width; RESET_PC, default 32'h0, first fetch address; CNT_WIDTH, default 16, statistics counter width.
REQ-002 SHALL have ports (name, direction, width, meaning):
- i_clk, input, 1, the single clock.
- i_rst_n, input, 1, asynchronous active-low reset.
- i_stall, input, 1, hazard stall that freezes fetch.
- id_pc, input, DATA_WIDTH, PC of the instruction in IF/ID.
- id_is_branch, input, 1, IF/ID opcode is B_TYPE.
- prediction, input, 1, predictor taken bit for the IF/ID instruction.
- branch_target, input, DATA_WIDTH, predictor target for the IF/ID instruction.
- ex_mem_is_branch, input, 1, EX/MEM opcode is B_TYPE.
- ex_mem_branch_taken, input, 1, resolved direction.
- ex_mem_branch_target, input, DATA_WIDTH, resolved target.
- o_pc, output, DATA_WIDTH, fetch address.
- o_fetch_valid, output, 1, o_pc is a real fetch.
- o_flush_if_id, output, 1, squash IF/ID.
- o_flush_id_ex, output, 1, squash ID/EX.
- o_mispredict, output, 1, one-cycle mispredict pulse.
- o_branch_cnt, output, CNT_WIDTH, resolved branches.
- o_mispredict_cnt, output, CNT_WIDTH, mispredictions.

Function
REQ-003 SHALL hold a 2-entry shadow pipeline (slot EX, slot MEM), each entry = {valid, pred_taken, pred_target, pc}, tracking branches from ID to EX/MEM.
REQ-004 SHALL, when not stalled, load slot EX with {id_is_branch, prediction, branch_target, id_pc} and move slot EX into slot MEM each cycle; when i_stall=1 and no mispredict, both slots SHALL hold.
REQ-005 SHALL declare a mispredict when ex_mem_is_branch=1 and slot MEM valid=1 and either ex_mem_branch_taken differs from pred_taken, or both are taken and ex_mem_branch_target differs from pred_target.
REQ-006 SHALL drive o_mispredict, o_flush_if_id and o_flush_id_ex combinationally high in the mispredict cycle.
REQ-007 SHALL use the corrected PC = ex_mem_branch_taken ? ex_mem_branch_target : slot MEM pc + 4 (modulo 2^DATA_WIDTH).
REQ-008 SHALL update o_pc at the next edge by priority:
- (1) mispredict -> corrected PC, regardless of i_stall;
- (2) i_stall -> hold;
- (3) id_is_branch & prediction -> branch_target, with o_flush_if_id=1 that cycle;
- (4) otherwise -> o_pc + 4, wrapping at 2^DATA_WIDTH.
REQ-009 SHALL, on mispredict, clear slot EX valid and slot MEM valid at the next edge, so squashed branches are never resolved.
REQ-010 SHALL suppress the ID predicted-taken redirect and its flush in any cycle where a mispredict occurs.
REQ-011 SHALL implement FSM states:
- BOOT: o_fetch_valid=0 and o_pc=RESET_PC held; always moves to RUN after one cycle.
- RUN: o_fetch_valid=1; moves to RECOVER on mispredict.
- RECOVER: o_fetch_valid=0 for one cycle with o_pc already at the corrected PC; a mispredict in RECOVER is impossible (slots invalid) and SHALL be ignored; always moves back to RUN.
REQ-012 SHALL force o_flush_if_id and o_flush_id_ex high throughout BOOT.
REQ-013 SHALL increment o_branch_cnt each cycle with ex_mem_is_branch=1 and slot MEM valid=1, and o_mispredict_cnt on each mispredict; both SHALL saturate at all-ones.
REQ-014 SHALL ignore ex_mem_is_branch when slot MEM valid=0, with no mispredict and no count.

Reset
REQ-015 SHALL, while i_rst_n=0, asynchronously set:
- o_pc=RESET_PC, state=BOOT;
- both slots all-zero;
- both counters=0;
- o_fetch_valid=0, o_mispredict=0.
REQ-016 SHALL, on reset asserted mid-recovery, abandon the redirect and restart from RESET_PC via BOOT.

Structure
REQ-017 SHALL take B_TYPE opcode, the FSM state encoding (BOOT, RUN, RECOVER) and the PC increment constant 4 from the shared pipeline package.
REQ-018 SHALL implement each shadow slot as one instance of sub-module branch_shadow_reg (enable, clear, async reset).

Verification
REQ-019 SHALL cover these directed scenarios:
- Reset release: first edge o_pc=0x0, o_fetch_valid=0; next edge o_fetch_valid=1; following edge o_pc=0x4.
- Predicted-taken at id_pc=0x10, target 0x40: o_flush_if_id=1 that cycle; next o_pc=0x40.
- Predicted not-taken at 0x20, resolved taken to 0x80: o_mispredict pulse; o_pc=0x80; RECOVER for one cycle; o_mispredict_cnt=1.
- Predicted taken 0x40, resolved not-taken, branch pc 0x20: o_pc=0x24; both flushes asserted.
- Mispredict with i_stall=1 and an ID predicted-taken branch in the same cycle: o_pc=corrected PC, no ID redirect; stall overridden.
- Force o_branch_cnt to 0xFFFF, then resolve one more branch: counter stays 0xFFFF; o_pc=0xFFFFFFFC with no branch wraps to 0x0.
